// File: rtl/serial_ripple_subtractor_if.sv
// serial_ripple_subtractor_if: operand/result stream bundle for the serial subtractor
//   slave  (subtractor side): takes A_in, B_in, Bw_in, valid_in, ready_in; drives ready_out, D_out, Bw_out, V_out, valid_out
//   master (producer/consumer side): the mirror image
interface serial_ripple_subtractor_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             Bw_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] D_out;
  logic             Bw_out;
  logic             V_out;
  logic             valid_out;
  logic             ready_in;
  modport slave (
    input  A_in, B_in, Bw_in, valid_in, ready_in,
    output ready_out, D_out, Bw_out, V_out, valid_out
  );
  modport master (
    output A_in, B_in, Bw_in, valid_in, ready_in,
    input  ready_out, D_out, Bw_out, V_out, valid_out
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: D = A - B - Bw_in computed SLICE bits per clock with a registered borrow
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : slave side of the operand/result valid-ready stream
module serial_ripple_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input logic clk_in,
  input logic rst_n_in,
  serial_ripple_subtractor_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             a_msb, b_msb, borrow, bw_q, v_q;
  logic [CW-1:0]    cnt;
  logic [SLICE:0]   diff;
  logic             last, accept;
  // operands shift right so the active slice is always the low SLICE bits
  assign diff   = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, borrow};
  assign last   = cnt == CW'(N - 1);
  assign accept = state == IDLE && bus.valid_in;
  assign bus.ready_out = state == IDLE;
  assign bus.valid_out = state == DONE;
  assign bus.D_out     = d_q;
  assign bus.Bw_out    = bw_q;
  assign bus.V_out     = v_q;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE && bus.ready_in) state_nx = IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      borrow <= 1'b0;
      bw_q   <= 1'b0;
      v_q    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_q    <= bus.A_in;
      b_q    <= bus.B_in;
      a_msb  <= bus.A_in[WIDTH-1];
      b_msb  <= bus.B_in[WIDTH-1];
      borrow <= bus.Bw_in;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_q    <= a_q >> SLICE;
      b_q    <= b_q >> SLICE;
      d_q[cnt*SLICE +: SLICE] <= diff[SLICE-1:0];
      borrow <= diff[SLICE];
      cnt    <= cnt + CW'(1);
      // on the top slice diff[SLICE-1] is the result MSB
      if (last) begin
        bw_q <= diff[SLICE];
        v_q  <= (a_msb ^ b_msb) & (diff[SLICE-1] ^ a_msb);
      end
    end
  end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: randomized self-checking bench against an arithmetic reference model
module tb_serial_ripple_subtractor;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int compared = 0;
  int mismatched = 0;
  serial_ripple_subtractor_if #(.WIDTH(32)) bus();
  serial_ripple_subtractor #(.WIDTH(32), .SLICE(4)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .bus(bus.slave)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bw);
    logic [32:0] full;
    logic v;
    full = {1'b0, a} - {1'b0, b} - {32'd0, bw};
    v = (a[31] != b[31]) && (full[31] != a[31]);
    return {v, full[32], full[31:0]};
  endfunction
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bw,
                        output logic [33:0] got, output int lat);
    int t;
    t = 0;
    while (!bus.ready_out && t < 50) begin @(posedge clk_in); #1; t++; end
    bus.A_in = a; bus.B_in = b; bus.Bw_in = bw; bus.valid_in = 1'b1;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    bus.A_in = $urandom; bus.B_in = $urandom; bus.Bw_in = 1'($urandom);
    lat = 0;
    while (!bus.valid_out && lat < 50) begin @(posedge clk_in); #1; lat++; end
    got = {bus.V_out, bus.Bw_out, bus.D_out};
    bus.ready_in = 1'b1;
    @(posedge clk_in); #1;
    bus.ready_in = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    compared++;
    if ({bus.ready_out, bus.valid_out, bus.Bw_out, bus.V_out, bus.D_out} !== {4'b1000, 32'd0}) begin
      mismatched++;
      $display("FAIL reset_held: rdy/vld/bw/v/d=%b%b%b%b %h expected 1000 00000000",
               bus.ready_out, bus.valid_out, bus.Bw_out, bus.V_out, bus.D_out);
    end
    @(negedge clk_in); rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    compared++;
    if ({bus.ready_out, bus.valid_out, bus.D_out} !== {2'b10, 32'd0}) begin
      mismatched++;
      $display("FAIL reset_release: rdy/vld/d=%b%b %h expected 10 00000000",
               bus.ready_out, bus.valid_out, bus.D_out);
    end
  endtask
  task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic bw, input logic [33:0] req);
    logic [33:0] got;
    int lat;
    run_op(a, b, bw, got, lat);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: v/bw/d=%b%b %h expected %b%b %h", name, got[33], got[32], got[31:0],
               req[33], req[32], req[31:0]);
    end
    compared++;
    if (lat !== 8) begin
      mismatched++;
      $display("FAIL %s_latency: %0d cycles expected 8", name, lat);
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] a1, b1, a2, b2;
    logic [33:0] e1, e2;
    int t;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = model(a1, b1, 1'b0);
    e2 = model(a2, b2, 1'b1);
    bus.A_in = a1; bus.B_in = b1; bus.Bw_in = 1'b0; bus.valid_in = 1'b1;
    @(posedge clk_in); #1;
    bus.A_in = a2; bus.B_in = b2; bus.Bw_in = 1'b1;
    t = 0;
    while (!bus.valid_out && t < 50) begin @(posedge clk_in); #1; t++; end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({bus.valid_out, bus.ready_out, bus.V_out, bus.Bw_out, bus.D_out} !== {2'b10, e1}) begin
        mismatched++;
        $display("FAIL backpressure_hold[%0d]: vld/rdy/v/bw/d=%b%b%b%b %h expected 10%b%b %h", i,
                 bus.valid_out, bus.ready_out, bus.V_out, bus.Bw_out, bus.D_out, e1[33], e1[32], e1[31:0]);
      end
      @(posedge clk_in); #1;
    end
    bus.ready_in = 1'b1;
    @(posedge clk_in); #1;
    bus.ready_in = 1'b0;
    compared++;
    if ({bus.valid_out, bus.ready_out} !== 2'b01) begin
      mismatched++;
      $display("FAIL backpressure_release: vld/rdy=%b%b expected 01", bus.valid_out, bus.ready_out);
    end
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    compared++;
    if (bus.ready_out !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_accept: ready_out=%b expected 0", bus.ready_out);
    end
    t = 0;
    while (!bus.valid_out && t < 50) begin @(posedge clk_in); #1; t++; end
    compared++;
    if ({bus.V_out, bus.Bw_out, bus.D_out} !== e2 || t !== 8) begin
      mismatched++;
      $display("FAIL backpressure_second: v/bw/d=%b%b %h lat=%0d expected %b%b %h lat=8",
               bus.V_out, bus.Bw_out, bus.D_out, t, e2[33], e2[32], e2[31:0]);
    end
    bus.ready_in = 1'b1;
    @(posedge clk_in); #1;
    bus.ready_in = 1'b0;
  endtask
  task automatic test_reset_mid_run();
    bus.A_in = 32'h5; bus.B_in = 32'h3; bus.Bw_in = 1'b0; bus.valid_in = 1'b1;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #4 rst_n_in = 1'b0;
    #1;
    compared++;
    if ({bus.valid_out, bus.ready_out, bus.Bw_out, bus.V_out, bus.D_out} !== {4'b0100, 32'd0}) begin
      mismatched++;
      $display("FAIL reset_mid_run: vld/rdy/bw/v/d=%b%b%b%b %h expected 0100 00000000",
               bus.valid_out, bus.ready_out, bus.Bw_out, bus.V_out, bus.D_out);
    end
    #2 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    compared++;
    if ({bus.valid_out, bus.ready_out} !== 2'b01) begin
      mismatched++;
      $display("FAIL reset_mid_run_idle: vld/rdy=%b%b expected 01", bus.valid_out, bus.ready_out);
    end
    test_vector("after_reset", 32'h5, 32'h3, 1'b0, {2'b00, 32'h2});
  endtask
  task automatic test_back_to_back();
    int first, second, t;
    first = -1; second = -1;
    bus.A_in = $urandom; bus.B_in = $urandom; bus.Bw_in = 1'b0;
    bus.valid_in = 1'b1; bus.ready_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.ready_out) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      @(posedge clk_in); #1;
    end
    bus.valid_in = 1'b0;
    compared++;
    if (second - first !== 10) begin
      mismatched++;
      $display("FAIL back_to_back_period: %0d cycles expected 10", second - first);
    end
    t = 0;
    while (!bus.ready_out && t < 50) begin @(posedge clk_in); #1; t++; end
    bus.ready_in = 1'b0;
  endtask
  task automatic test_random();
    logic [31:0] a, b;
    logic bw;
    logic [33:0] got, req;
    int lat;
    for (int i = 0; i < 1500; i++) begin
      a = $urandom; b = $urandom; bw = 1'($urandom);
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = {a[31], 31'd0};
      req = model(a, b, bw);
      run_op(a, b, bw, got, lat);
      compared++;
      if (got !== req || lat !== 8) begin
        mismatched++;
        $display("FAIL random[%0d] a=%h b=%h bw=%b: v/bw/d=%b%b %h lat=%0d expected %b%b %h lat=8",
                 i, a, b, bw, got[33], got[32], got[31:0], lat, req[33], req[32], req[31:0]);
      end
    end
  endtask
  initial begin
    bus.A_in = '0; bus.B_in = '0; bus.Bw_in = 1'b0; bus.valid_in = 1'b0; bus.ready_in = 1'b0;
    test_reset();
    test_vector("basic", 32'h5, 32'h3, 1'b0, {2'b00, 32'h2});
    test_vector("borrow_ripple", 32'h0, 32'h1, 1'b0, {2'b01, 32'hFFFFFFFF});
    test_vector("overflow_neg", 32'h80000000, 32'h1, 1'b0, {2'b10, 32'h7FFFFFFF});
    test_vector("overflow_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, {2'b11, 32'h80000000});
    test_vector("equal_borrow_in", 32'h12345678, 32'h12345678, 1'b1, {2'b01, 32'hFFFFFFFF});
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
